// File: rtl/ctrl_mc.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/mem/writeback sequencing with Moore/Mealy control strobes.
// Outputs are combinational (zero latency); MEM stalls on LOD/STR until mem_rdy; async active-high reset.
module ctrl_mc #(
  parameter int OPW      = 4,
  parameter int MMW      = 4,
  parameter int CNTW     = 16,
  parameter int IMM_CODE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic [MMW-1:0]  mm,
  input  logic [MMW-1:0]  stat,
  input  logic            mem_rdy,
  output logic            ir_load,
  output logic            pc_write,
  output logic            pc_sel,
  output logic            pc_rel,
  output logic            rf_we,
  output logic            wb_sel,
  output logic            dm_we,
  output logic            stat_we,
  output logic            halt,
  output logic [1:0]      alu_op,
  output logic [2:0]      state,
  output logic [CNTW-1:0] instr_cnt
);

  localparam logic [2:0] S_START     = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEM       = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;

  localparam logic [OPW-1:0] OP_LOD = OPW'(1);
  localparam logic [OPW-1:0] OP_STR = OPW'(2);
  localparam logic [OPW-1:0] OP_BRA = OPW'(4);
  localparam logic [OPW-1:0] OP_BRR = OPW'(5);
  localparam logic [OPW-1:0] OP_BNE = OPW'(6);
  localparam logic [OPW-1:0] OP_BNR = OPW'(7);
  localparam logic [OPW-1:0] OP_ALU = OPW'(8);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);
  localparam logic [MMW-1:0] IMM_MM = MMW'(IMM_CODE);

  logic [2:0] state_q;
  logic [2:0] state_d;

  logic       is_lod;
  logic       is_str;
  logic       is_mem;
  logic       is_alu;
  logic       flag_hit;
  logic       br_taken;
  logic       br_rel;
  logic [1:0] alu_code;

  assign is_lod   = (opcode == OP_LOD);
  assign is_str   = (opcode == OP_STR);
  assign is_mem   = is_lod | is_str;
  assign is_alu   = (opcode == OP_ALU);
  assign flag_hit = |(stat & mm);
  assign br_taken = ((opcode == OP_BRA || opcode == OP_BRR) &&  flag_hit) ||
                    ((opcode == OP_BNE || opcode == OP_BNR) && !flag_hit);
  assign br_rel   = (opcode == OP_BRR) || (opcode == OP_BNR);
  assign alu_code = is_mem ? 2'b10 :
                    (is_alu && mm == IMM_MM) ? 2'b01 : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_START;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_d = S_MEM;
      S_MEM:       state_d = (is_mem && !mem_rdy) ? S_MEM : S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;  // START and the unused encoding 7
    endcase
  end

  always_comb begin
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    pc_rel   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    dm_we    = 1'b0;
    stat_we  = 1'b0;
    halt     = 1'b0;
    alu_op   = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_op  = alu_code;
        stat_we = is_alu;
        if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          pc_rel   = br_rel;
        end
      end
      S_MEM: begin
        alu_op = alu_code;
        dm_we  = is_str;
      end
      S_WRITEBACK: begin
        alu_op = alu_code;
        rf_we  = is_alu | is_lod;
        wb_sel = is_lod;
      end
      S_HALT:  halt = 1'b1;
      default: ;
    endcase
  end

  // Retire count advances on the WRITEBACK->FETCH edge; HLT never reaches WRITEBACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        instr_cnt <= '0;
    else if (state_q == S_WRITEBACK && ~&instr_cnt) instr_cnt <= instr_cnt + CNTW'(1);
  end

  assign state = state_q;

endmodule

// File: tb/tb_ctrl_mc.sv
// Scoreboard bench for ctrl_mc: driver pushes per-cycle expectations, negedge monitor compares.
module tb_ctrl_mc;

  typedef struct packed {
    logic [2:0]  st;
    logic        ir_load, pc_write, pc_sel, pc_rel, rf_we, wb_sel, dm_we, stat_we, halt;
    logic [1:0]  alu_op;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opcode = '0, mm = '0, stat = '0;
  logic        mem_rdy = 1'b0;

  logic        ir_load, pc_write, pc_sel, pc_rel, rf_we, wb_sel, dm_we, stat_we, halt;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] instr_cnt;

  logic [8:0]  d2_flags;
  logic [1:0]  d2_alu_op;
  logic [2:0]  d2_state;
  logic [1:0]  d2_cnt;

  int   checks = 0;
  int   errors = 0;
  int   retired = 0;
  exp_t expq[$];

  ctrl_mc dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mm(mm), .stat(stat), .mem_rdy(mem_rdy),
    .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel), .pc_rel(pc_rel),
    .rf_we(rf_we), .wb_sel(wb_sel), .dm_we(dm_we), .stat_we(stat_we), .halt(halt),
    .alu_op(alu_op), .state(state), .instr_cnt(instr_cnt)
  );

  ctrl_mc #(.CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .opcode(opcode), .mm(mm), .stat(stat), .mem_rdy(mem_rdy),
    .ir_load(d2_flags[0]), .pc_write(d2_flags[1]), .pc_sel(d2_flags[2]), .pc_rel(d2_flags[3]),
    .rf_we(d2_flags[4]), .wb_sel(d2_flags[5]), .dm_we(d2_flags[6]), .stat_we(d2_flags[7]),
    .halt(d2_flags[8]), .alu_op(d2_alu_op), .state(d2_state), .instr_cnt(d2_cnt)
  );

  always #5 clk = ~clk;

  // Reference: what each phase of an instruction must show, from the opcode's meaning.
  function automatic exp_t mk(input int ph, input logic [3:0] op, input logic [3:0] m,
                              input logic [3:0] s, input int ret);
    exp_t e;
    bit   mem_op, alu, cond, taken;
    logic [1:0] code;
    e      = '0;
    e.st   = 3'(ph);
    mem_op = (op == 4'd1) || (op == 4'd2);
    alu    = (op == 4'd8);
    cond   = ((s & m) != 4'd0);
    taken  = ((op == 4'd4 || op == 4'd5) && cond) || ((op == 4'd6 || op == 4'd7) && !cond);
    code   = mem_op ? 2'd2 : (alu && m == 4'd8) ? 2'd1 : 2'd0;
    case (ph)
      1: begin e.ir_load = 1'b1; e.pc_write = 1'b1; end
      3: begin
        e.alu_op  = code;
        e.stat_we = alu;
        e.pc_write = taken;
        e.pc_sel   = taken;
        e.pc_rel   = taken && (op == 4'd5 || op == 4'd7);
      end
      4: begin e.alu_op = code; e.dm_we = (op == 4'd2); end
      5: begin e.alu_op = code; e.rf_we = alu || op == 4'd1; e.wb_sel = (op == 4'd1); end
      6: e.halt = 1'b1;
      default: ;
    endcase
    e.cnt  = (ret > 65535) ? 16'hffff : 16'(ret);
    e.cnt2 = (ret > 3) ? 2'd3 : 2'(ret);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ph);
    expq.push_back(mk(ph, opcode, mm, stat, retired));
  endtask

  // Called one time unit after a rising edge; reset must act before any further edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_cnt", 32'(instr_cnt), 32'd0);
    chk("async_rst_cnt2", 32'(d2_cnt), 32'd0);
    chk("async_rst_halt", 32'(halt), 32'd0);
    retired = 0;
    push(0);
    step();
    rst = 1'b0;
    push(0);
    step();
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                           input int stalls, input bit abort_mid_mem);
    bit mem_op;
    mem_op  = (op == 4'd1) || (op == 4'd2);
    opcode  = op;
    mm      = m;
    stat    = s;
    mem_rdy = 1'($urandom);
    push(1); step();
    mem_rdy = 1'($urandom);
    push(2); step();
    if (op == 4'd15) begin
      for (int i = 0; i < 20; i++) begin
        mem_rdy = 1'($urandom);
        push(6); step();
      end
      return;
    end
    mem_rdy = 1'($urandom);
    push(3); step();
    if (mem_op) begin
      for (int j = 0; j <= stalls; j++) begin
        if (abort_mid_mem && j == 2) begin
          do_reset();
          return;
        end
        mem_rdy = (j == stalls);
        push(4); step();
      end
    end else begin
      mem_rdy = 1'($urandom);
      push(4); step();
    end
    mem_rdy = 1'($urandom);
    push(5); step();
    retired++;
  endtask

  initial begin : monitor
    exp_t e, a;
    int   n;
    n = 0;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        a = {state, ir_load, pc_write, pc_sel, pc_rel, rf_we, wb_sel, dm_we, stat_we, halt,
             alu_op, instr_cnt, d2_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle%0d state=%0d: got %h, required %h", n, e.st, a, e);
        end
        n++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1);
  end

  initial begin : driver
    @(posedge clk);
    #1;
    push(0); step();
    rst = 1'b0;
    push(0); step();

    run_instr(4'd8, 4'd8, 4'd0, 0, 1'b0);   // ALU immediate
    run_instr(4'd1, 4'd3, 4'd0, 3, 1'b0);   // LOD, 3 stall cycles
    run_instr(4'd2, 4'd0, 4'd0, 0, 1'b0);   // STR, no stall
    run_instr(4'd5, 4'd2, 4'd2, 0, 1'b0);   // BRR taken
    run_instr(4'd6, 4'd2, 4'd2, 0, 1'b0);   // BNE not taken
    run_instr(4'd8, 4'd3, 4'd5, 0, 1'b0);   // ALU register
    run_instr(4'd4, 4'd4, 4'd3, 0, 1'b0);   // BRA not taken
    run_instr(4'd7, 4'd4, 4'd3, 0, 1'b0);   // BNR taken

    for (int i = 0; i < 40; i++)
      run_instr(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom),
                $urandom_range(0, 3), 1'b0);

    run_instr(4'd15, 4'd0, 4'd0, 0, 1'b0);
    chk("halt_cnt_held", 32'(instr_cnt), 32'(retired));
    do_reset();

    for (int i = 0; i < 5; i++)
      run_instr(4'd0, 4'($urandom), 4'($urandom), 0, 1'b0);
    run_instr(4'd1, 4'd0, 4'd0, 3, 1'b1);   // LOD aborted by reset during stall

    for (int i = 0; i < 10; i++)
      run_instr(4'($urandom_range(0, 14)), 4'($urandom), 4'($urandom),
                $urandom_range(0, 3), 1'b0);

    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_mc.md
CTRL_MC -- requirements
Module: ctrl_mc

Parameters
REQ-001 SHALL declare OPW, default 4, opcode width.
REQ-002 SHALL declare MMW, default 4, branch-mask/addressing-mode field width (also stat width).
REQ-003 SHALL declare CNTW, default 16, retired-instruction counter width.
REQ-004 SHALL declare IMM_CODE, default 8, mm value selecting immediate mode.

Interface
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 opcode  in  OPW  current instruction opcode (0 NOOP, 1 LOD, 2 STR, 3 SWP, 4 BRA, 5 BRR, 6 BNE, 7 BNR, 8 ALU, 15 HLT).
REQ-008 mm  in  MMW  addressing mode / branch mask.
REQ-009 stat  in  MMW  status flags.
REQ-010 mem_rdy  in  1  data memory completion handshake.
REQ-011 Outputs, all 1 bit unless noted: ir_load, pc_write, pc_sel, pc_rel, rf_we, wb_sel, dm_we, stat_we, halt; alu_op out 2; state out 3; instr_cnt out CNTW.

Function
REQ-012 States SHALL be START=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6; value 7 SHALL decode as START.
REQ-013 Transitions: START->FETCH, FETCH->DECODE, DECODE->HALT if opcode==15 else EXECUTE, EXECUTE->MEM, MEM->WRITEBACK, WRITEBACK->FETCH, HALT->HALT.
REQ-014 MEM with opcode LOD or STR SHALL hold until mem_rdy==1 at a rising edge; other opcodes leave MEM after one cycle regardless of mem_rdy.
REQ-015 Outputs SHALL be combinational from state, opcode, mm, stat; all 0 unless listed below.
REQ-016 FETCH: ir_load=1, pc_write=1, pc_sel=0 (PC+1).
REQ-017 EXECUTE, ALU: alu_op=01 if mm==IMM_CODE else 00; stat_we=1.
REQ-018 EXECUTE/MEM/WRITEBACK, LOD or STR: alu_op=10 (address add); ALU in MEM/WRITEBACK holds its EXECUTE alu_op.
REQ-019 Branch taken: BRA/BRR when (stat & mm)!=0; BNE/BNR when (stat & mm)==0.
REQ-020 EXECUTE, branch taken: pc_write=1, pc_sel=1, pc_rel=1 for BRR/BNR, 0 for BRA/BNE; not taken: no PC outputs.
REQ-021 MEM, STR: dm_we=1 every cycle in MEM until exit.
REQ-022 WRITEBACK: rf_we=1 for ALU and LOD; wb_sel=1 for LOD, 0 otherwise.
REQ-023 HALT: halt=1; no other output asserted; leaves only via rst.
REQ-024 NOOP, SWP and undefined opcodes SHALL traverse all states asserting nothing beyond FETCH outputs.
REQ-025 instr_cnt SHALL increment on each WRITEBACK->FETCH edge, saturating at all ones; HLT SHALL not count.
REQ-026 state output SHALL equal the present-state register.

Reset
REQ-027 rst==1 SHALL force state=START and instr_cnt=0 immediately, independent of clk, including mid-MEM stall.
REQ-028 While rst==1 all outputs SHALL be 0; first rising edge after deassertion enters FETCH.

Verification
REQ-029 rst pulse, then ALU opcode 8, mm=8 -> FETCH,DECODE,EXECUTE(alu_op=01,stat_we=1),MEM,WRITEBACK(rf_we=1,wb_sel=0); instr_cnt=1.
REQ-030 LOD, mem_rdy low 3 cycles in MEM -> MEM held 4 cycles, then WRITEBACK rf_we=1, wb_sel=1.
REQ-031 STR, mem_rdy=1 -> dm_we=1 exactly one cycle, alu_op=10, rf_we never 1.
REQ-032 BRR stat=0010 mm=0010 -> EXECUTE pc_write=1,pc_sel=1,pc_rel=1; BNE same values -> no pc_write in EXECUTE.
REQ-033 HLT -> DECODE->HALT, halt=1 held 20 cycles, instr_cnt unchanged; rst -> START, halt=0.
REQ-034 CNTW=2, 5 NOOPs -> instr_cnt 1,2,3,3,3; rst asserted mid-MEM stall -> state=0 without clock edge.
